// File: rtl/lock_chamber_ctrl.sv
// Vessel lock chamber sequencer: runs arrival/departure cycles with timed
// pressure equalization and interlocked outer/inner port commands.
module lock_chamber_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned PRESS_SEC = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arrive_req,
  input  logic       depart_req,
  input  logic       vessel_in,
  output logic       outer_open,
  output logic       inner_open,
  output logic       pressurizing,
  output logic       depressurizing,
  output logic       at_outer,
  output logic       busy,
  output logic [9:0] sec_left,
  output logic       arrive_done,
  output logic       depart_done
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam logic [9:0] SecLoad = 10'(PRESS_SEC);

  typedef enum logic [3:0] {
    IDLE, A_EQ, A_OPEN_OUT, A_PDOWN, A_OPEN_IN,
    D_EQ, D_OPEN_IN, D_PUP, D_OPEN_OUT, DONE
  } stateT;

  stateT           state;
  logic            isArrive;
  logic [PreW-1:0] prescale;
  logic [6:0]      portBits;
  logic            phaseTick;
  logic            phaseEnd;

  assign phaseTick = (prescale == PreMax);
  assign phaseEnd  = phaseTick && (sec_left == 10'd1);

  assign {outer_open, inner_open, pressurizing, depressurizing,
          busy, arrive_done, depart_done} = portBits;

  // Output pattern a state presents; registered on entry to that state.
  function automatic logic [6:0] decode(input stateT s, input logic arr);
    logic [6:0] v;
    v = '0;
    case (s)
      A_OPEN_OUT, D_OPEN_OUT: v[6] = 1'b1;
      A_OPEN_IN,  D_OPEN_IN:  v[5] = 1'b1;
      A_EQ,       D_PUP:      v[4] = 1'b1;
      A_PDOWN,    D_EQ:       v[3] = 1'b1;
      DONE: begin
        v[1] = arr;
        v[0] = !arr;
      end
      default: v = '0;
    endcase
    v[2] = (s != IDLE);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      isArrive <= 1'b0;
      prescale <= '0;
      sec_left <= '0;
      at_outer <= 1'b0;
      portBits <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arrive_req && !vessel_in) begin
            isArrive <= 1'b1;
            if (at_outer) begin
              state    <= A_OPEN_OUT;
              portBits <= decode(A_OPEN_OUT, 1'b1);
            end else begin
              state    <= A_EQ;
              portBits <= decode(A_EQ, 1'b1);
              sec_left <= SecLoad;
              prescale <= '0;
            end
          end else if (depart_req && !vessel_in) begin
            isArrive <= 1'b0;
            if (at_outer) begin
              state    <= D_EQ;
              portBits <= decode(D_EQ, 1'b0);
              sec_left <= SecLoad;
              prescale <= '0;
            end else begin
              state    <= D_OPEN_IN;
              portBits <= decode(D_OPEN_IN, 1'b0);
            end
          end
        end

        // Timed pressure phases share the prescaler and seconds countdown.
        A_EQ, A_PDOWN, D_EQ, D_PUP: begin
          if (phaseTick) begin
            prescale <= '0;
            sec_left <= sec_left - 10'd1;
          end else begin
            prescale <= prescale + 1'b1;
          end
          if (phaseEnd) begin
            case (state)
              A_EQ: begin
                at_outer <= 1'b1;
                state    <= A_OPEN_OUT;
                portBits <= decode(A_OPEN_OUT, isArrive);
              end
              A_PDOWN: begin
                at_outer <= 1'b0;
                state    <= A_OPEN_IN;
                portBits <= decode(A_OPEN_IN, isArrive);
              end
              D_EQ: begin
                at_outer <= 1'b0;
                state    <= D_OPEN_IN;
                portBits <= decode(D_OPEN_IN, isArrive);
              end
              default: begin
                at_outer <= 1'b1;
                state    <= D_OPEN_OUT;
                portBits <= decode(D_OPEN_OUT, isArrive);
              end
            endcase
          end
        end

        A_OPEN_OUT, D_OPEN_IN: begin
          if (vessel_in) begin
            state    <= (state == A_OPEN_OUT) ? A_PDOWN : D_PUP;
            portBits <= decode((state == A_OPEN_OUT) ? A_PDOWN : D_PUP, isArrive);
            sec_left <= SecLoad;
            prescale <= '0;
          end
        end

        A_OPEN_IN, D_OPEN_OUT: begin
          if (!vessel_in) begin
            state    <= DONE;
            portBits <= decode(DONE, isArrive);
          end
        end

        default: begin
          state    <= IDLE;
          portBits <= decode(IDLE, isArrive);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Directed bench for lock_chamber_ctrl with TICK_DIV=4, PRESS_SEC=3
// (12-cycle pressure phases).
module tb_lock_chamber_ctrl;

  logic       clk;
  logic       rst;
  logic       arrive_req;
  logic       depart_req;
  logic       vessel_in;
  logic       outer_open;
  logic       inner_open;
  logic       pressurizing;
  logic       depressurizing;
  logic       at_outer;
  logic       busy;
  logic [9:0] sec_left;
  logic       arrive_done;
  logic       depart_done;

  int tests = 0;
  int fails = 0;

  lock_chamber_ctrl #(.TICK_DIV(4), .PRESS_SEC(3)) dut (
    .clk(clk), .rst(rst),
    .arrive_req(arrive_req), .depart_req(depart_req), .vessel_in(vessel_in),
    .outer_open(outer_open), .inner_open(inner_open),
    .pressurizing(pressurizing), .depressurizing(depressurizing),
    .at_outer(at_outer), .busy(busy), .sec_left(sec_left),
    .arrive_done(arrive_done), .depart_done(depart_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {outer, inner, press, depress, at_outer, busy, arrive_done, depart_done}
  logic [7:0] obsVec;
  assign obsVec = {outer_open, inner_open, pressurizing, depressurizing,
                   at_outer, busy, arrive_done, depart_done};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [7:0] exp);
    chk(tag, 16'(obsVec), 16'(exp));
  endtask

  // Checks all 12 cycles of a pressure phase, starting on its first cycle.
  task automatic phase(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 12; i++) begin
      chkv(tag, exp);
      chk({tag, "_sec"}, 16'(sec_left), 16'(3 - i / 4));
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; arrive_req = 1'b0; depart_req = 1'b0; vessel_in = 1'b0;
    tick(); tick();
    chkv("reset", 8'b0000_0000);
    chk("reset_sec", 16'(sec_left), 16'(0));
    rst = 1'b0;
    tick();

    // Full arrival from reset (chamber at inner pressure)
    arrive_req = 1'b1;
    tick();
    phase("a_eq", 8'b0010_0100);
    chkv("a_open_out", 8'b1000_1100);
    chk("a_sec_zero", 16'(sec_left), 16'(0));
    tick(); tick();
    chkv("a_open_hold", 8'b1000_1100);
    vessel_in = 1'b1;
    tick();
    phase("a_pdown", 8'b0001_1100);
    chkv("a_open_in", 8'b0100_0100);
    vessel_in = 1'b0;
    tick();
    chkv("a_done", 8'b0000_0110);
    arrive_req = 1'b0;
    tick();
    chkv("a_idle", 8'b0000_0000);
    tick();
    chkv("a_idle2", 8'b0000_0000);

    // Departure from at_outer=0 skips D_EQ
    depart_req = 1'b1;
    tick();
    chkv("d0_open_in", 8'b0100_0100);
    vessel_in = 1'b1;
    tick();
    phase("d0_pup", 8'b0010_0100);
    chkv("d0_open_out", 8'b1000_1100);
    vessel_in = 1'b0;
    tick();
    chkv("d0_done", 8'b0000_1101);
    depart_req = 1'b0;
    tick();
    chkv("d0_idle", 8'b0000_1000);

    // Departure from at_outer=1
    depart_req = 1'b1;
    tick();
    phase("d1_eq", 8'b0001_1100);
    chkv("d1_open_in", 8'b0100_0100);
    vessel_in = 1'b1;
    tick();
    phase("d1_pup", 8'b0010_0100);
    chkv("d1_open_out", 8'b1000_1100);
    vessel_in = 1'b0;
    tick();
    chkv("d1_done", 8'b0000_1101);
    depart_req = 1'b0;
    tick();
    chkv("d1_idle", 8'b0000_1000);

    // Simultaneous requests: arrival first, one idle cycle, then departure
    arrive_req = 1'b1; depart_req = 1'b1;
    tick();
    chkv("s_open_out", 8'b1000_1100);
    vessel_in = 1'b1;
    tick();
    phase("s_pdown", 8'b0001_1100);
    chkv("s_open_in", 8'b0100_0100);
    vessel_in = 1'b0;
    tick();
    chkv("s_adone", 8'b0000_0110);
    arrive_req = 1'b0;
    tick();
    chkv("s_gap", 8'b0000_0000);
    tick();
    chkv("s_dep_open_in", 8'b0100_0100);
    vessel_in = 1'b1;
    tick();
    phase("s_pup", 8'b0010_0100);
    chkv("s_open_out2", 8'b1000_1100);
    vessel_in = 1'b0;
    tick();
    chkv("s_ddone", 8'b0000_1101);
    depart_req = 1'b0;
    tick();
    chkv("s_idle", 8'b0000_1000);

    // Requests ignored while the chamber is occupied in IDLE
    vessel_in = 1'b1; arrive_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chkv("ign_occupied", 8'b0000_1000);
    end
    arrive_req = 1'b0; vessel_in = 1'b0;
    tick();

    // A departure pulse during an arrival is dropped
    arrive_req = 1'b1;
    tick();
    chkv("p_open_out", 8'b1000_1100);
    depart_req = 1'b1;
    tick();
    depart_req = 1'b0;
    chkv("p_open_out2", 8'b1000_1100);
    vessel_in = 1'b1;
    tick();
    phase("p_pdown", 8'b0001_1100);
    chkv("p_open_in", 8'b0100_0100);
    vessel_in = 1'b0;
    tick();
    chkv("p_done", 8'b0000_0110);
    arrive_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chkv("p_no_depart", 8'b0000_0000);
    end

    // Reset mid A_PDOWN with sec_left=2
    arrive_req = 1'b1;
    tick();
    phase("r_eq", 8'b0010_0100);
    chkv("r_open_out", 8'b1000_1100);
    vessel_in = 1'b1;
    tick();
    repeat (4) tick();
    chkv("r_pdown", 8'b0001_1100);
    chk("r_sec2", 16'(sec_left), 16'(2));
    rst = 1'b1; arrive_req = 1'b0; vessel_in = 1'b0;
    tick();
    chkv("r_rst", 8'b0000_0000);
    chk("r_rst_sec", 16'(sec_left), 16'(0));
    rst = 1'b0;
    tick();
    chkv("r_no_done", 8'b0000_0000);

    // Random stimulus: interlock invariants must hold every cycle
    for (int i = 0; i < 1000; i++) begin
      vessel_in  = 1'($urandom_range(0, 1));
      arrive_req = ($urandom_range(0, 7) == 0) ? ~arrive_req : arrive_req;
      depart_req = ($urandom_range(0, 7) == 0) ? ~depart_req : depart_req;
      tick();
      chk("il_door_overlap", 16'(outer_open & inner_open), 16'(0));
      chk("il_door_pump", 16'((outer_open | inner_open) & (pressurizing | depressurizing)), 16'(0));
      chk("il_pump_both", 16'(pressurizing & depressurizing), 16'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lock_chamber_ctrl.md
# lock_chamber_ctrl

Responder side of the vessel arrival/departure request interface. Accepts level-held `arrive_req` / `depart_req` from the switch-conditioning front end and runs the full lock cycle. Each cycle equalizes the chamber pressure over a timed interval, opens and closes the outer and inner ports in interlocked order, and returns a one-cycle completion pulse. It sits between the request front end and the port/pump actuator outputs.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per one-second tick, ≥1.
- `PRESS_SEC`, 7: seconds per pressurize/depressurize phase, 1..1023.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `arrive_req` in 1: vessel outside requests entry. Already synchronized; held until `arrive_done`.
- `depart_req` in 1: vessel at station requests exit. Already synchronized; held until `depart_done`.
- `vessel_in` in 1: chamber occupancy sensor, synchronized.
- `outer_open` out 1: outer port open command.
- `inner_open` out 1: inner port open command.
- `pressurizing` out 1: pump raising the chamber to outer pressure.
- `depressurizing` out 1: pump lowering the chamber to inner pressure.
- `at_outer` out 1: chamber currently equalized to outer pressure.
- `busy` out 1: high in every state except IDLE.
- `sec_left` out 10: seconds remaining in the current pressure phase; 0 otherwise.
- `arrive_done` out 1: one-cycle pulse when an arrival cycle completes.
- `depart_done` out 1: one-cycle pulse when a departure cycle completes.

## Operation
- States: IDLE, A_EQ, A_OPEN_OUT, A_PDOWN, A_OPEN_IN, D_EQ, D_OPEN_IN, D_PUP, D_OPEN_OUT, DONE.
- All outputs are Moore, decoded from registered state and registers. No output depends combinationally on an input.

**IDLE**
- If `arrive_req=1` and `vessel_in=0`: start an arrival. Go to A_EQ if `at_outer=0`, else go to A_OPEN_OUT.
- Else if `depart_req=1` and `vessel_in=0`: start a departure. Go to D_EQ if `at_outer=1`, else go to D_OPEN_IN.
- Simultaneous requests: arrival wins. The held `depart_req` is served after the arrival completes.
- Any request while `vessel_in=1` in IDLE is ignored.

**Arrival sequence**
- A_EQ: `pressurizing=1` for the pressure phase, then set `at_outer=1` and go to A_OPEN_OUT.
- A_OPEN_OUT: `outer_open=1` until `vessel_in=1`, then go to A_PDOWN.
- A_PDOWN: `depressurizing=1` for the phase, then clear `at_outer` and go to A_OPEN_IN.
- A_OPEN_IN: `inner_open=1` until `vessel_in=0`, then go to DONE.

**Departure sequence**
- D_EQ: depressurize, clear `at_outer`, go to D_OPEN_IN.
- D_OPEN_IN: `inner_open=1` until `vessel_in=1`, then go to D_PUP.
- D_PUP: pressurize, set `at_outer`, go to D_OPEN_OUT.
- D_OPEN_OUT: `outer_open=1` until `vessel_in=0`, then go to DONE.

**DONE**
- Pulse `arrive_done` or `depart_done` according to the sequence type latched at start. Go to IDLE.

**Interlocks (invariants)**
- `outer_open` and `inner_open` are never both 1.
- No port is open while `pressurizing` or `depressurizing` is 1.
- `pressurizing` and `depressurizing` are never both 1.

**Requests during busy**
- Request inputs are not sampled outside IDLE and are not queued.
- A request still held when the FSM returns to IDLE is served then.

## Timing
- Request sampled at edge N in IDLE → new state and its outputs visible after edge N. IDLE→first action latency is 1 cycle.
- Pressure phase:
  - The prescaler clears on phase entry.
  - A tick fires every `TICK_DIV` cycles.
  - `sec_left` loads `PRESS_SEC` on entry and decrements on each tick.
  - The phase exits on the tick that takes `sec_left` from 1 to 0.
  - Total phase length is exactly `PRESS_SEC*TICK_DIV` cycles.
  - The prescaler counter is wide enough to hold `TICK_DIV-1`.
- Door states: exit on the edge that samples the `vessel_in` condition. The next state's outputs apply the following cycle, so door close to next action is 1 cycle.
- DONE lasts exactly 1 cycle, and `busy=0` the cycle after. A still-held request can therefore restart the FSM with 1 idle cycle between cycles.
- Reset values (any time, including mid-cycle):
  - State IDLE; all outputs 0.
  - `at_outer=0`: the chamber is taken to be at inner pressure.
  - Prescaler and `sec_left` = 0.
  - Any in-progress cycle is abandoned without a done pulse.

## Test plan
Bench parameters: `TICK_DIV=4`, `PRESS_SEC=3` (phase = 12 cycles).

- **Full arrival from reset.** `arrive_req=1`. Response: `pressurizing` for 12 cycles with `sec_left` 3,2,1; `at_outer=1`; `outer_open=1`. Drive `vessel_in=1`: `outer_open=0`, `depressurizing` for 12 cycles, `at_outer=0`, `inner_open=1`. Drive `vessel_in=0`: `arrive_done` pulses 1 cycle, then `busy=0`.
- **Departure from `at_outer=1`.** Response: D_EQ depressurizes 12 cycles, then `inner_open`. Then `vessel_in` 1 → 12-cycle pressurize → `outer_open`. Then `vessel_in` 0 → `depart_done`. Departure from `at_outer=0` skips D_EQ and gives `inner_open=1` 1 cycle after the request.
- **Simultaneous requests in IDLE.** Both requests asserted together. Response: arrival runs first, `arrive_done`, 1 idle cycle, then the departure runs.
- **Requests ignored.** `vessel_in=1` in IDLE with `arrive_req=1`: no state change for 20 cycles. A `depart_req` pulse during an arrival: not served.
- **Reset mid-phase.** Assert `rst` at `sec_left=2` during A_PDOWN. Next cycle: all outputs 0, `at_outer=0`, no done pulse.
- **Interlocks.** Random `vessel_in` toggling over 1000 cycles: door-overlap and door-during-pump assertions never fire.
